// File: rtl/instruction_decode_pkg.sv
// Shared processor definitions: instruction field layout, opcode encodings,
// datapath width and register-address width used by decode and the register file.
package instruction_decode_pkg;

  localparam int DATA_W = 20;
  localparam int NREGS  = 16;
  localparam int REG_AW = 4;

  localparam int OPC_LSB = 16;
  localparam int RD_LSB  = 12;
  localparam int RS_LSB  = 8;
  localparam int RT_LSB  = 4;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_OR  = 4'b0001,
    OP_AND = 4'b0010,
    OP_NOT = 4'b0011,
    OP_NOP = 4'b1111
  } opcode_e;

  localparam logic [19:0] NOP_WORD = {OP_NOP, 16'h0000};

  function automatic logic isAluOp(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_OR) || (op == OP_AND) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// Register file: one synchronous write port, two combinational read ports.
// r0 is hardwired to zero and a same-cycle write is forwarded to the readers.
module register_file #(
  parameter int DATA_W = 20,
  parameter int NREGS  = 16,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wen,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddrA,
  output logic [DATA_W-1:0] rdataA,
  input  logic [AW-1:0]     raddrB,
  output logic [DATA_W-1:0] rdataB
);

  logic [DATA_W-1:0] mem_q [NREGS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (wen && (waddr != '0)) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdataA = mem_q[raddrA];
    rdataB = mem_q[raddrB];
    if (wen && (waddr == raddrA)) rdataA = wdata;
    if (wen && (waddr == raddrB)) rdataB = wdata;
    if (raddrA == '0) rdataA = '0;
    if (raddrB == '0) rdataB = '0;
  end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: field extraction, operand read, pending-write scoreboard hazard
// detection, and the registered hand-off to execute.
module instruction_decode #(
  parameter int DATA_W = 20,
  parameter int NREGS  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_instruction,
  output logic              id_ready,
  input  logic              wb_en,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              ex_valid,
  output logic [1:0]        ex_control,
  output logic [DATA_W-1:0] ex_opA,
  output logic [DATA_W-1:0] ex_opB,
  output logic [DATA_W-1:0] ex_instruction,
  output logic [3:0]        ex_rd,
  output logic              ex_wen,
  output logic              illegal_op
);

  import instruction_decode_pkg::*;

  logic [3:0] opcode, rd, rs, rt;
  logic       isAlu, isNop, stall, accept, issueAlu;
  logic       unusedLowBits;

  logic [DATA_W-1:0] readA, readB;
  logic [NREGS-1:0]  clearVec, setVec, pendingEff;
  logic [NREGS-1:0]  pending_q, pending_d;

  logic              exValid_q, exValid_d;
  logic [1:0]        exControl_q, exControl_d;
  logic [DATA_W-1:0] exOpA_q, exOpA_d;
  logic [DATA_W-1:0] exOpB_q, exOpB_d;
  logic [DATA_W-1:0] exInstr_q, exInstr_d;
  logic [3:0]        exRd_q, exRd_d;
  logic              exWen_q, exWen_d;
  logic              illegal_q, illegal_d;

  assign opcode = if_instruction[OPC_LSB +: 4];
  assign rd     = if_instruction[RD_LSB  +: 4];
  assign rs     = if_instruction[RS_LSB  +: 4];
  assign rt     = if_instruction[RT_LSB  +: 4];
  assign unusedLowBits = ^if_instruction[3:0];

  assign isAlu = isAluOp(opcode);
  assign isNop = (opcode == OP_NOP);

  register_file #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .AW     (4)
  ) u_regfile (
    .clock  (clock),
    .reset  (reset),
    .wen    (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddrA (rs),
    .rdataA (readA),
    .raddrB (rt),
    .rdataB (readB)
  );

  // A writeback landing this cycle already resolves its hazard.
  always_comb begin
    clearVec   = '0;
    setVec     = '0;
    if (wb_en) clearVec[wb_addr] = 1'b1;
    pendingEff = pending_q & ~clearVec;
    stall      = if_valid && isAlu &&
                 (pendingEff[rs] || ((opcode != OP_NOT) && pendingEff[rt]) || pendingEff[rd]);
    id_ready   = !stall || flush;
    accept     = if_valid && id_ready && !flush;
    issueAlu   = accept && isAlu;
    if (issueAlu && (rd != 4'd0)) setVec[rd] = 1'b1;
    pending_d    = (pending_q & ~clearVec) | setVec;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    exValid_d   = issueAlu;
    exWen_d     = issueAlu && (rd != 4'd0);
    illegal_d   = accept && !isAlu && !isNop;
    exControl_d = exControl_q;
    exOpA_d     = exOpA_q;
    exOpB_d     = exOpB_q;
    exInstr_d   = exInstr_q;
    exRd_d      = exRd_q;
    if (issueAlu) begin
      exControl_d = opcode[1:0];
      exOpA_d     = readA;
      exOpB_d     = readB;
      exInstr_d   = if_instruction;
      exRd_d      = rd;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_q   <= '0;
      exValid_q   <= 1'b0;
      exControl_q <= '0;
      exOpA_q     <= '0;
      exOpB_q     <= '0;
      exInstr_q   <= '0;
      exRd_q      <= '0;
      exWen_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      exValid_q   <= exValid_d;
      exControl_q <= exControl_d;
      exOpA_q     <= exOpA_d;
      exOpB_q     <= exOpB_d;
      exInstr_q   <= exInstr_d;
      exRd_q      <= exRd_d;
      exWen_q     <= exWen_d;
      illegal_q   <= illegal_d;
    end
  end

  assign ex_valid       = exValid_q;
  assign ex_control     = exControl_q;
  assign ex_opA         = exOpA_q;
  assign ex_opB         = exOpB_q;
  assign ex_instruction = exInstr_q;
  assign ex_rd          = exRd_q;
  assign ex_wen         = exWen_q;
  assign illegal_op     = illegal_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Testbench for instruction_decode: directed scenarios plus randomized traffic,
// all checked against a behavioural model of registers, pending set and outputs.
module tb_instruction_decode;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_valid = 1'b0;
  logic [19:0] if_instruction = '0;
  logic        id_ready;
  logic        wb_en = 1'b0;
  logic [3:0]  wb_addr = '0;
  logic [19:0] wb_data = '0;
  logic        flush = 1'b0;
  logic        ex_valid;
  logic [1:0]  ex_control;
  logic [19:0] ex_opA, ex_opB, ex_instruction;
  logic [3:0]  ex_rd;
  logic        ex_wen;
  logic        illegal_op;

  int checks = 0;
  int failures = 0;

  instruction_decode #(.DATA_W(20), .NREGS(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .id_ready       (id_ready),
    .wb_en          (wb_en),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_control     (ex_control),
    .ex_opA         (ex_opA),
    .ex_opB         (ex_opB),
    .ex_instruction (ex_instruction),
    .ex_rd          (ex_rd),
    .ex_wen         (ex_wen),
    .illegal_op     (illegal_op)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [19:0] mRegs [16];
  bit          mPend [16];
  bit          mValid, mWen, mIllegal;
  logic [1:0]  mControl;
  logic [19:0] mOpA, mOpB, mInstr;
  logic [3:0]  mRd;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      mRegs[i] = '0;
      mPend[i] = 1'b0;
    end
    mValid = 0; mWen = 0; mIllegal = 0;
    mControl = '0; mOpA = '0; mOpB = '0; mInstr = '0; mRd = '0;
  endtask

  function automatic bit busy(input int r, input bit we, input int wa);
    return mPend[r] && !(we && wa == r);
  endfunction

  function automatic logic [19:0] modelRead(input int r, input bit we, input int wa, input logic [19:0] wd);
    if (r == 0) return '0;
    if (we && wa == r) return wd;
    return mRegs[r];
  endfunction

  task automatic checkAllOutputs(input string ctx);
    checkOutput({ctx, ".ex_valid"}, ex_valid, mValid);
    checkOutput({ctx, ".ex_wen"}, ex_wen, mWen);
    checkOutput({ctx, ".illegal_op"}, illegal_op, mIllegal);
    checkOutput({ctx, ".ex_control"}, ex_control, mControl);
    checkOutput({ctx, ".ex_opA"}, ex_opA, mOpA);
    checkOutput({ctx, ".ex_opB"}, ex_opB, mOpB);
    checkOutput({ctx, ".ex_rd"}, ex_rd, mRd);
    checkOutput({ctx, ".ex_instruction"}, ex_instruction, mInstr);
  endtask

  // One clock of traffic: drive after the falling edge, check id_ready before
  // the rising edge, advance the model on the edge, then check registered outputs.
  task automatic applyStimulus(input string ctx, input bit v, input logic [19:0] instr,
                               input bit we, input logic [3:0] wa, input logic [19:0] wd,
                               input bit fl);
    int  op, rd, rs, rt;
    bit  alu, stall, ready, accept;
    logic [19:0] a, b;
    @(negedge clock);
    if_valid = v; if_instruction = instr; wb_en = we; wb_addr = wa; wb_data = wd; flush = fl;
    op = int'(instr[19:16]); rd = int'(instr[15:12]); rs = int'(instr[11:8]); rt = int'(instr[7:4]);
    alu = (op <= 3);
    stall = v && alu && (busy(rs, we, int'(wa)) || (op != 3 && busy(rt, we, int'(wa))) || busy(rd, we, int'(wa)));
    ready = !stall || fl;
    accept = v && ready && !fl;
    #1 checkOutput({ctx, ".id_ready"}, id_ready, ready);
    @(posedge clock);
    a = modelRead(rs, we, int'(wa), wd);
    b = modelRead(rt, we, int'(wa), wd);
    mIllegal = accept && !alu && op != 15;
    mValid = accept && alu;
    mWen = accept && alu && rd != 0;
    if (accept && alu) begin
      mControl = 2'(op); mOpA = a; mOpB = b; mRd = 4'(rd); mInstr = instr;
    end
    if (we) mPend[wa] = 1'b0;
    if (accept && alu && rd != 0) mPend[rd] = 1'b1;
    if (we && wa != 0) mRegs[wa] = wd;
    #1 checkAllOutputs(ctx);
  endtask

  function automatic logic [3:0] pickTarget();
    int start = $urandom_range(0, 15);
    for (int i = 0; i < 16; i++) if (mPend[(start + i) % 16]) return 4'((start + i) % 16);
    return 4'($urandom_range(1, 15));
  endfunction

  initial begin
    logic [3:0]  op, rdR, rsR, rtR, wa;
    logic [19:0] instr, wd;
    int sel;

    modelReset();
    #2;
    checkAllOutputs("reset");
    checkOutput("reset.id_ready", id_ready, 1);
    #1 reset = 1'b1;

    // Write r1=5, r2=3, then ADD r3,r1,r2
    applyStimulus("wb_r1", 0, '0, 1, 4'd1, 20'd5, 0);
    applyStimulus("wb_r2", 0, '0, 1, 4'd2, 20'd3, 0);
    applyStimulus("add", 1, 20'h03120, 0, 4'd0, '0, 0);
    checkOutput("add.const_valid", ex_valid, 1);
    checkOutput("add.const_ctrl", ex_control, 0);
    checkOutput("add.const_opA", ex_opA, 5);
    checkOutput("add.const_opB", ex_opB, 3);
    checkOutput("add.const_rd", ex_rd, 3);
    checkOutput("add.const_wen", ex_wen, 1);

    // OR r4,r3,r1 waits on r3 and issues on the r3 writeback edge
    applyStimulus("raw_stall1", 1, 20'h14310, 0, 4'd0, '0, 0);
    checkOutput("raw.const_ready", id_ready, 0);
    checkOutput("raw.const_valid", ex_valid, 0);
    applyStimulus("raw_stall2", 1, 20'h14310, 0, 4'd0, '0, 0);
    applyStimulus("raw_issue", 1, 20'h14310, 1, 4'd3, 20'h00007, 0);
    checkOutput("raw.const_issue_valid", ex_valid, 1);
    checkOutput("raw.const_issue_opA", ex_opA, 20'h00007);
    checkOutput("raw.const_issue_ctrl", ex_control, 1);
    applyStimulus("wb_r4", 0, '0, 1, 4'd4, 20'h11111, 0);

    // Same-cycle writeback bypass
    applyStimulus("bypass", 1, 20'h26550, 1, 4'd5, 20'hABCDE, 0);
    checkOutput("bypass.const_opA", ex_opA, 20'hABCDE);
    checkOutput("bypass.const_opB", ex_opB, 20'hABCDE);
    checkOutput("bypass.const_valid", ex_valid, 1);
    applyStimulus("wb_r6", 0, '0, 1, 4'd6, 20'h00042, 0);

    // Illegal opcode: one-cycle pulse, no scoreboard effect
    applyStimulus("illegal", 1, 20'h59000, 0, 4'd0, '0, 0);
    checkOutput("illegal.const_pulse", illegal_op, 1);
    checkOutput("illegal.const_valid", ex_valid, 0);
    applyStimulus("illegal_after", 1, 20'h0A900, 0, 4'd0, '0, 0);
    checkOutput("illegal_after.const_pulse", illegal_op, 0);
    checkOutput("illegal_after.const_valid", ex_valid, 1);
    applyStimulus("wb_r10", 0, '0, 1, 4'd10, 20'h00001, 0);

    // Flush discards the ADD without marking r9
    applyStimulus("flush", 1, 20'h09120, 0, 4'd0, '0, 1);
    checkOutput("flush.const_valid", ex_valid, 0);
    applyStimulus("flush_after", 1, 20'h0A990, 0, 4'd0, '0, 0);
    checkOutput("flush_after.const_valid", ex_valid, 1);
    applyStimulus("wb_r10b", 0, '0, 1, 4'd10, 20'h00002, 0);
    applyStimulus("not", 1, 20'h37200, 0, 4'd0, '0, 0);
    checkOutput("not.const_opA", ex_opA, 3);
    checkOutput("not.const_wen", ex_wen, 1);
    applyStimulus("add_r0", 1, 20'h08000, 0, 4'd0, '0, 0);
    checkOutput("add_r0.const_opA", ex_opA, 0);
    checkOutput("add_r0.const_opB", ex_opB, 0);

    // Reset asserted while a hazard is stalling decode
    applyStimulus("pre_reset", 1, 20'h0B120, 0, 4'd0, '0, 0);
    @(negedge clock);
    if_valid = 1; if_instruction = 20'h1CB00; wb_en = 0; flush = 0;
    #1 checkOutput("midreset.stall_ready", id_ready, 0);
    reset = 1'b0;
    #1;
    modelReset();
    checkAllOutputs("midreset");
    checkOutput("midreset.id_ready", id_ready, 1);
    if_valid = 0;
    #1 reset = 1'b1;
    applyStimulus("post_reset", 1, 20'h03120, 0, 4'd0, '0, 0);
    checkOutput("post_reset.const_opA", ex_opA, 0);

    // Randomized traffic with hazards, bypass, flushes and illegal ops
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 11);
      if (sel < 8) op = 4'(sel % 4);
      else if (sel < 10) op = 4'hF;
      else op = 4'($urandom_range(4, 14));
      rdR = 4'($urandom_range(0, 7));
      rsR = 4'($urandom_range(0, 7));
      rtR = 4'($urandom_range(0, 7));
      instr = {op, rdR, rsR, rtR, 4'($urandom_range(0, 15))};
      wa = ($urandom_range(0, 3) != 0) ? pickTarget() : 4'($urandom_range(0, 15));
      wd = 20'($urandom);
      applyStimulus("rand", $urandom_range(0, 9) < 8, instr, $urandom_range(0, 1) == 1,
                    wa, wd, $urandom_range(0, 9) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 SHALL have parameters DATA_W (default 20, datapath and instruction width) and NREGS (default 16, register count, 4-bit address).
REQ-002 SHALL have ports `clock` (in, 1, sole clock, rising edge) and `reset` (in, 1, asynchronous, active-low).
REQ-003 SHALL have ports `if_valid` (in, 1, fetch holds an instruction) and `if_instruction` (in, 20, instruction word).
REQ-004 SHALL have port `id_ready` (out, 1, combinational, decode accepts this cycle).
REQ-005 SHALL have write-back ports `wb_en` (in, 1), `wb_addr` (in, 4) and `wb_data` (in, 20), forming the register write port.
REQ-006 SHALL have port `flush` (in, 1, discard the incoming instruction).
REQ-007 SHALL have outputs `ex_valid` (1), `ex_control` (2, ALU op), `ex_opA` (20) and `ex_opB` (20, read-data-2).
REQ-008 SHALL have outputs `ex_instruction` (20, propagated word), `ex_rd` (4), `ex_wen` (1) and `illegal_op` (1, registered pulse).

Function
REQ-009 Instruction fields SHALL be: opcode [19:16], rd [15:12], rs [11:8], rt [7:4]; bits [3:0] are ignored.
REQ-010 Opcodes SHALL be 0000 ADD, 0001 OR, 0010 AND, 0011 NOT (reads rs only), 1111 NOP; all others are illegal and decode as NOP.
REQ-011 `ex_control` SHALL equal opcode[1:0] for ALU ops.
REQ-012 The register file SHALL be NREGS x DATA_W; r0 reads 0; writes to r0 are ignored.
REQ-013 A write SHALL occur at the rising edge when `wb_en`=1.
REQ-014 Reads SHALL be write-through: a same-cycle write to a source register supplies `wb_data`.
REQ-015 A pending-write scoreboard (NREGS bits) SHALL track destinations issued to execute and not yet written back; r0 is never pending.
REQ-016 stall SHALL be asserted when `if_valid` and the opcode is ALU and (rs pending, or rt pending for a non-NOT op, or rd pending).
REQ-017 A pending bit cleared by a same-cycle `wb_en` SHALL NOT count toward stall.
REQ-018 `id_ready` SHALL be !stall OR `flush`.
REQ-019 Accept SHALL be `if_valid` && `id_ready` && !`flush`; latency is 1 cycle from accept to `ex_valid`.
REQ-020 On an accepted ALU op, the next edge SHALL give: `ex_valid`=1; `ex_opA`=R[rs]; `ex_opB`=R[rt]; `ex_rd`=rd; `ex_wen`=(rd!=0); `ex_instruction`=word; scoreboard[rd] set if rd!=0.
REQ-021 On an accepted NOP or illegal op, the next edge SHALL give `ex_valid`=0 and `ex_wen`=0.
REQ-022 An accepted illegal op SHALL additionally produce `illegal_op`=1 for exactly one cycle.
REQ-023 On a stall, flush or no `if_valid`, the next edge SHALL give `ex_valid`=0 and `ex_wen`=0, with other ex_* fields held.
REQ-024 `flush` SHALL NOT modify the scoreboard or the register file; in-flight writebacks still clear their bits.
REQ-025 If set and clear target the same register in one edge, set SHALL win.
REQ-026 `wb_en` for a non-pending register SHALL write data and leave the scoreboard unchanged.
REQ-027 The execute side SHALL have no backpressure; ex_* outputs update every edge.

Reset
REQ-028 With `reset`=0 (asynchronous), all register-file entries, the scoreboard, all ex_* outputs and `illegal_op` SHALL be 0; `id_ready` is then 1.
REQ-029 Reset asserted mid-operation SHALL drop in-flight state without further writes; operation resumes on the first edge after release.

Structure
REQ-030 Opcode encodings, field bit positions, DATA_W, register address width and NOP encoding SHALL live in the shared processor package.
REQ-031 The register file SHALL be a sub-module `register_file` (one synchronous write port, two combinational read ports with bypass).

Verification
REQ-032 Writeback r1=5, r2=3, then ADD r3,r1,r2 (0x03120) SHALL give next cycle `ex_valid`=1, `ex_control`=00, `ex_opA`=5, `ex_opB`=3, `ex_rd`=3, `ex_wen`=1.
REQ-033 ADD r3 followed by OR r4,r3,r1 SHALL hold `id_ready`=0 until `wb_en` r3; the OR issues on the edge of the r3 writeback.
REQ-034 Same-cycle `wb_en` r5=0xABCDE with AND r6,r5,r5 accepted SHALL give `ex_opA`=`ex_opB`=0xABCDE and no stall.
REQ-035 Opcode 0101 accepted SHALL give `illegal_op`=1 for one cycle, `ex_valid`=0 and no scoreboard change.
REQ-036 `flush`=1 with a valid ADD SHALL give `ex_valid`=0, `id_ready`=1 and scoreboard unchanged; NOT r7,r2 then ADD r8,r0,r0 SHALL give `ex_opA`=R2, `ex_wen`=1, then `ex_opA`=`ex_opB`=0.
REQ-037 `reset`=0 mid-stall SHALL give all outputs 0 immediately and `id_ready`=1.
